// File: rtl/stereo_pkg.sv
// Shared window geometry and pixel/window types for the stereo window generator.
package stereo_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int WIN           = 5;
    localparam int TAPS          = WIN - 1;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;
    typedef pixel_t [WIN-1:0]         win_row_t;
    typedef win_row_t [WIN-1:0]       window_t;

endpackage

// File: rtl/win_line_core.sv
// One camera path: four single-port line buffers (read-before-write on the
// current column) feeding a 5x5 shift window. Counters live in the parent.
module win_line_core
    import stereo_pkg::*;
#(
    parameter  int IMG_W = 640,
    parameter  int PIX_W = PIX_W_DEFAULT,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [COL_W-1:0]                    col,
    input  logic [PIX_W-1:0]                    pix,
    output logic [WIN-1:0][WIN-1:0][PIX_W-1:0]  win
);

    // tap[k] is the pixel from row-(k+1) at this column
    logic [TAPS-1:0][PIX_W-1:0] tap;

    for (genvar k = 0; k < TAPS; k++) begin : g_lb
        logic [PIX_W-1:0] mem [IMG_W];
        logic [PIX_W-1:0] wr_data;

        assign tap[k] = mem[col];

        if (k == 0) begin : g_first
            assign wr_data = pix;
        end else begin : g_chain
            assign wr_data = tap[k-1];
        end

        always_ff @(posedge clk) begin
            if (en) begin
                mem[col] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (en) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            // oldest row (top) comes from the deepest tap
            for (int r = 0; r < TAPS; r++) begin
                win[r][WIN-1] <= tap[TAPS-1-r];
            end
            win[WIN-1][WIN-1] <= pix;
        end
    end

endmodule

// File: rtl/stereo_window_gen.sv
// Pairs raster-order left/right pixel streams into 5x5 windows for the
// disparity core; shared raster counters, one line/window core per camera.
module stereo_window_gen
    import stereo_pkg::*;
#(
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    parameter  int PIX_W = PIX_W_DEFAULT,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid,
    input  logic                                i_sof,
    input  logic [PIX_W-1:0]                    i_pix_l,
    input  logic [PIX_W-1:0]                    i_pix_r,
    output logic                                o_valid,
    output logic [WIN-1:0][WIN-1:0][PIX_W-1:0]  o_win_l,
    output logic [WIN-1:0][WIN-1:0][PIX_W-1:0]  o_win_r,
    output logic [ROW_W-1:0]                    o_row,
    output logic [COL_W-1:0]                    o_col,
    output logic                                o_frame_done
);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_cur;
    logic [COL_W-1:0] col_cur;
    logic             last_col;
    logic             last_row;
    logic             in_frame;

    // start-of-frame forces position (0,0) so a partial frame is simply dropped
    assign row_cur  = i_sof ? '0 : row_q;
    assign col_cur  = i_sof ? '0 : col_q;
    assign last_col = (col_cur == COL_W'(IMG_W - 1));
    assign last_row = (row_cur == ROW_W'(IMG_H - 1));
    assign in_frame = (row_cur >= ROW_W'(WIN - 1)) && (col_cur >= COL_W'(WIN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q        <= '0;
            col_q        <= '0;
            o_valid      <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= i_valid && in_frame;
            o_frame_done <= i_valid && last_row && last_col;
            if (i_valid) begin
                o_row <= row_cur - ROW_W'(2);
                o_col <= col_cur - COL_W'(2);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_cur + ROW_W'(1);
                end else begin
                    col_q <= col_cur + COL_W'(1);
                    row_q <= row_cur;
                end
            end
        end
    end

    win_line_core #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_core_l (
        .clk (i_clk),
        .rst (i_rst),
        .en  (i_valid),
        .col (col_cur),
        .pix (i_pix_l),
        .win (o_win_l)
    );

    win_line_core #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_core_r (
        .clk (i_clk),
        .rst (i_rst),
        .en  (i_valid),
        .col (col_cur),
        .pix (i_pix_r),
        .win (o_win_r)
    );

endmodule
